vga_timing_out: RTL and testbench



---
 rtl/vga_timing_out.sv | 163 ++++++++++++++++
 tb/tb_vga_timing_out.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_out.sv
// vga_timing_out: VGA scan counters, sync/blank alignment and pin registers.
// Optional macro VGA_TEST_PATTERN_EN adds a test_pattern input (8 colour bars).
module vga_timing_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       colour_in,
  input  logic [5:0] fg_colour,
  input  logic [5:0] bg_colour,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_pattern,
`endif
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       frame_start,
  output logic       h_sync,
  output logic       v_sync,
  output logic [5:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // tag bits: [0] active, [1] hsync, [2] vsync, [5:3] bar index
`ifdef VGA_TEST_PATTERN_EN
  localparam int TW = 6;
`else
  localparam int TW = 3;
`endif

  logic [9:0]    cnt_h_q, cnt_h_d;
  logic [9:0]    cnt_v_q, cnt_v_d;
  logic [TW-1:0] tag_raw;
  logic [TW-1:0] tag_dly;
  logic [5:0]    rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;

  // Totals must fit the 10-bit counters.
  always @(posedge clk) begin
    assert (H_TOTAL <= 1024 && V_TOTAL <= 1024)
      else $error("vga_timing_out: totals exceed 10-bit counters");
  end

  // Next scan position: H every clock, V on H wrap.
  always_comb begin
    cnt_h_d = cnt_h_q + 10'd1;
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == H_LAST) begin
      cnt_h_d = 10'd0;
      cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_h_q <= 10'd0;
      cnt_v_q <= 10'd0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // Raw timing decoded from the counter registers.
  always_comb begin
    tag_raw    = '0;
    tag_raw[0] = (cnt_h_q < H_ACT) && (cnt_v_q < V_ACT);
    tag_raw[1] = (cnt_h_q >= H_SS) && (cnt_h_q < H_SE);
    tag_raw[2] = (cnt_v_q >= V_SS) && (cnt_v_q < V_SE);
`ifdef VGA_TEST_PATTERN_EN
    tag_raw[5:3] = cnt_h_q[9:7];
`endif
  end

  if (PIPE_DELAY == 0) begin : g_nopipe
    assign tag_dly = tag_raw;
  end else begin : g_pipe
    logic [TW-1:0] pipe_q [PIPE_DELAY];
    logic [TW-1:0] pipe_d [PIPE_DELAY];

    // Shift timing tags to match frame-buffer latency.
    always_comb begin
      pipe_d[0] = tag_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // Alignment stages clear to blank / sync inactive.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign tag_dly = pipe_q[PIPE_DELAY-1];
  end

  // Pixel colour and pin-polarity syncs for the output register.
  always_comb begin
    rgb_d = 6'b0;
    hs_d  = tag_dly[1] ^ ~SYNC_POL;
    vs_d  = tag_dly[2] ^ ~SYNC_POL;
    if (tag_dly[0]) begin
`ifdef VGA_TEST_PATTERN_EN
      if (test_pattern) begin
        rgb_d = {tag_dly[5], tag_dly[5], tag_dly[4],
                 tag_dly[4], tag_dly[3], tag_dly[3]};
      end else begin
        rgb_d = colour_in ? fg_colour : bg_colour;
      end
`else
      rgb_d = colour_in ? fg_colour : bg_colour;
`endif
    end
  end

  // Registered pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q <= 6'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign counter_H   = cnt_h_q;
  assign counter_V   = cnt_v_q;
  assign frame_start = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: table vectors plus a cycle-index reference model.
// Two instances: default 640x480 timing and a tiny frame for wrap coverage.
module tb_vga_timing_out;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [5:0] rgb;
  } obs_t;

  typedef struct {
    string      name;
    int         k;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic [5:0] rgb;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       col, s_col;
  logic [5:0] fg, bg, s_fg, s_bg;
  logic [9:0] counter_H, counter_V, s_h, s_v;
  logic       frame_start, h_sync, v_sync;
  logic       s_fs, s_hs, s_vs;
  logic [5:0] rgb_out, s_rgb;
`ifdef VGA_TEST_PATTERN_EN
  logic       tp;
`endif

  int  n_chk = 0;
  int  n_err = 0;
  int  k = 0;
  int  fs_cnt = 0;
  int  hs_first = -1;
  int  hs_len = 0;
  bit  dir_mode = 1'b1;
  bit  tp_v = 1'b0;

  bit         col_a   [2048];
  logic [5:0] fg_a    [2048];
  logic [5:0] bg_a    [2048];
  bit         s_col_a [2048];
  logic [5:0] s_fg_a  [2048];
  logic [5:0] s_bg_a  [2048];

  vec_t tab [16];

  always #5 clk = ~clk;

  vga_timing_out dut (
    .clk(clk), .reset(reset), .colour_in(col),
    .fg_colour(fg), .bg_colour(bg),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(tp),
`endif
    .counter_H(counter_H), .counter_V(counter_V),
    .frame_start(frame_start), .h_sync(h_sync),
    .v_sync(v_sync), .rgb_out(rgb_out)
  );

  vga_timing_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PIPE_DELAY(3), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .reset(reset), .colour_in(s_col),
    .fg_colour(s_fg), .bg_colour(s_bg),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .counter_H(s_h), .counter_V(s_v),
    .frame_start(s_fs), .h_sync(s_hs),
    .v_sync(s_vs), .rgb_out(s_rgb)
  );

  // Expected pins k clocks after reset release, from the timing rules.
  function automatic obs_t model(
    input int k_i, input int ha, input int hf, input int hw, input int hb,
    input int va, input int vf, input int vw, input int vb, input int d,
    input bit pol, input bit c, input logic [5:0] f, input logic [5:0] b,
    input bit tpat);
    obs_t o;
    int ht, vt, p, ph, pv, bar;
    ht    = ha + hf + hw + hb;
    vt    = va + vf + vw + vb;
    o.h   = 10'(k_i % ht);
    o.v   = 10'((k_i / ht) % vt);
    o.fs  = (o.h == 10'd0) && (o.v == 10'd0);
    o.hs  = ~pol;
    o.vs  = ~pol;
    o.rgb = 6'd0;
    if (k_i >= d + 1) begin
      p  = k_i - d - 1;
      ph = p % ht;
      pv = (p / ht) % vt;
      if (ph >= ha + hf && ph < ha + hf + hw) o.hs = pol;
      if (pv >= va + vf && pv < va + vf + vw) o.vs = pol;
      if (ph < ha && pv < va) begin
        if (tpat) begin
          bar   = ph / 128;
          o.rgb = 6'(((bar / 4) % 2) * 48 + ((bar / 2) % 2) * 12 + (bar % 2) * 3);
        end else begin
          o.rgb = c ? f : b;
        end
      end
    end
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL %s k=%0d: got h=%0d v=%0d fs=%b hs=%b vs=%b rgb=%h, want h=%0d v=%0d fs=%b hs=%b vs=%b rgb=%h",
                 nm, k, a.h, a.v, a.fs, a.hs, a.vs, a.rgb, e.h, e.v, e.fs, e.hs, e.vs, e.rgb);
    end
  endtask

  task automatic cmp_int(input string nm, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, a, e);
    end
  endtask

  task automatic check_reset(input string nm);
    obs_t a;
    a = {counter_H, counter_V, frame_start, h_sync, v_sync, rgb_out};
    cmp({nm, "_main"}, a, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 6'd0});
    a = {s_h, s_v, s_fs, s_hs, s_vs, s_rgb};
    cmp({nm, "_small"}, a, {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 6'd0});
  endtask

  task automatic check_vec(input vec_t t);
    n_chk++;
    if (counter_H !== t.h || counter_V !== t.v || h_sync !== t.hs ||
        v_sync !== t.vs || rgb_out !== t.rgb) begin
      n_err++;
      $display("FAIL %s k=%0d: got h=%0d v=%0d hs=%b vs=%b rgb=%h, want h=%0d v=%0d hs=%b vs=%b rgb=%h",
               t.name, k, counter_H, counter_V, h_sync, v_sync, rgb_out,
               t.h, t.v, t.hs, t.vs, t.rgb);
    end
  endtask

  // Frame-buffer stand-in: directed single dot at (10,0) or random data.
  task automatic drive();
    int p;
    p = k - 2;
    if (dir_mode) begin
      fg  = 6'h3F;
      bg  = 6'h03;
      col = (p >= 0) && (p % 800 == 10) && ((p / 800) % 525 == 0);
    end else begin
      fg  = 6'($urandom);
      bg  = 6'($urandom);
      col = 1'($urandom);
    end
    s_fg  = 6'($urandom);
    s_bg  = 6'($urandom);
    s_col = 1'($urandom);
    if (k < 2048) begin
      col_a[k]   = col;
      fg_a[k]    = fg;
      bg_a[k]    = bg;
      s_col_a[k] = s_col;
      s_fg_a[k]  = s_fg;
      s_bg_a[k]  = s_bg;
    end
  endtask

  task automatic check_all();
    obs_t e, a;
    int i;
    i = (k > 0) ? k - 1 : 0;
    e = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0,
              col_a[i], fg_a[i], bg_a[i], tp_v);
    a = {counter_H, counter_V, frame_start, h_sync, v_sync, rgb_out};
    cmp("main", a, e);
    e = model(k, 8, 2, 3, 2, 6, 1, 2, 2, 3, 1'b1,
              s_col_a[i], s_fg_a[i], s_bg_a[i], 1'b0);
    a = {s_h, s_v, s_fs, s_hs, s_vs, s_rgb};
    cmp("small", a, e);
    if (s_fs) fs_cnt++;
    if (!h_sync) begin
      if (hs_first < 0) hs_first = k;
      hs_len++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
    drive();
    check_all();
  endtask

  task automatic release_reset();
    reset    = 1'b1;
    k        = 0;
    fs_cnt   = 0;
    hs_first = -1;
    hs_len   = 0;
    drive();
    check_all();
  endtask

  initial begin
    tab[0]  = '{"release",    0,   10'd0,   10'd0, 1'b1, 1'b1, 6'h00};
    tab[1]  = '{"first_edge", 1,   10'd1,   10'd0, 1'b1, 1'b1, 6'h00};
    tab[2]  = '{"fill",       2,   10'd2,   10'd0, 1'b1, 1'b1, 6'h00};
    tab[3]  = '{"first_px",   3,   10'd3,   10'd0, 1'b1, 1'b1, 6'h03};
    tab[4]  = '{"pre_fg",     12,  10'd12,  10'd0, 1'b1, 1'b1, 6'h03};
    tab[5]  = '{"fg_px",      13,  10'd13,  10'd0, 1'b1, 1'b1, 6'h3F};
    tab[6]  = '{"post_fg",    14,  10'd14,  10'd0, 1'b1, 1'b1, 6'h03};
    tab[7]  = '{"last_px",    642, 10'd642, 10'd0, 1'b1, 1'b1, 6'h03};
    tab[8]  = '{"h640_blank", 643, 10'd643, 10'd0, 1'b1, 1'b1, 6'h00};
    tab[9]  = '{"pre_hs",     658, 10'd658, 10'd0, 1'b1, 1'b1, 6'h00};
    tab[10] = '{"hs_start",   659, 10'd659, 10'd0, 1'b0, 1'b1, 6'h00};
    tab[11] = '{"hs_end",     754, 10'd754, 10'd0, 1'b0, 1'b1, 6'h00};
    tab[12] = '{"post_hs",    755, 10'd755, 10'd0, 1'b1, 1'b1, 6'h00};
    tab[13] = '{"line_end",   799, 10'd799, 10'd0, 1'b1, 1'b1, 6'h00};
    tab[14] = '{"v_step",     800, 10'd0,   10'd1, 1'b1, 1'b1, 6'h00};
    tab[15] = '{"line1_px",   803, 10'd3,   10'd1, 1'b1, 1'b1, 6'h03};

    col = 1'b0; fg = 6'd0; bg = 6'd0;
    s_col = 1'b0; s_fg = 6'd0; s_bg = 6'd0;
`ifdef VGA_TEST_PATTERN_EN
    tp = 1'b0;
`endif

    repeat (5) begin
      @(negedge clk);
      check_reset("reset_hold");
    end

    release_reset();
    for (int i = 0; i < 16; i++) begin
      while (k < tab[i].k) step();
      check_vec(tab[i]);
    end
    while (k < 900) step();
    dir_mode = 1'b0;
    while (k < 1500) step();
    cmp_int("small_frame_starts", fs_cnt, 1500 / 165 + 1);

    // counter_H is 700 here, mid hsync; reset between edges.
    #2 reset = 1'b0;
    #1 check_reset("async_reset");
    repeat (3) begin
      @(negedge clk);
      check_reset("reset_hold2");
    end

    release_reset();
    while (k < 760) step();
    cmp_int("hs_first_after_reset", hs_first, 659);
    cmp_int("hs_width", hs_len, 96);

`ifdef VGA_TEST_PATTERN_EN
    reset = 1'b0;
    @(negedge clk);
    tp_v = 1'b1;
    tp   = 1'b1;
    release_reset();
    while (k < 3) step();
    check_vec('{"tp_h0", 3, 10'd3, 10'd0, 1'b1, 1'b1, 6'h00});
    while (k < 131) step();
    check_vec('{"tp_h128", 131, 10'd131, 10'd0, 1'b1, 1'b1, 6'h03});
    while (k < 515) step();
    check_vec('{"tp_h512", 515, 10'd515, 10'd0, 1'b1, 1'b1, 6'h30});
    while (k < 643) step();
    check_vec('{"tp_blank", 643, 10'd643, 10'd0, 1'b1, 1'b1, 6'h00});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
